// File: rtl/axi_w_pkg.sv
// Shared types for the AXI W-channel receiver: FSM states, FIFO entry layout, widths.
// Data width comes from the XLEN macro (default 64).
`ifndef XLEN
  `define XLEN 64
`endif

package axi_w_pkg;

  localparam int XLEN_P = `XLEN;
  localparam int STRB_W = XLEN_P / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN_P-1:0] data;
    logic [STRB_W-1:0] strb;
    logic [7:0]        beat;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/axi_w_if.sv
// Bundle of command, W, local write-port and completion signals for axi_w_receiver.
// Signal names keep the receiver's point of view (_i into it, _o out of it).
interface axi_w_if #(
  parameter int XLEN = axi_w_pkg::XLEN_P
);

  localparam int SW = XLEN / 8;

  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [7:0]      cmd_len_i;
  logic [XLEN-1:0] wdata_i;
  logic [SW-1:0]   wstrb_i;
  logic            wlast_i;
  logic            wvalid_i;
  logic            wready_o;
  logic            mem_valid_o;
  logic            mem_ready_i;
  logic [XLEN-1:0] mem_data_o;
  logic [SW-1:0]   mem_strb_o;
  logic [7:0]      mem_beat_o;
  logic            mem_last_o;
  logic            done_valid_o;
  logic            done_ready_i;
  logic            done_err_o;

  modport slave (
    input  cmd_valid_i, cmd_len_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
           mem_ready_i, done_ready_i,
    output cmd_ready_o, wready_o, mem_valid_o, mem_data_o, mem_strb_o,
           mem_beat_o, mem_last_o, done_valid_o, done_err_o
  );

  modport master (
    output cmd_valid_i, cmd_len_i, wdata_i, wstrb_i, wlast_i, wvalid_i,
           mem_ready_i, done_ready_i,
    input  cmd_ready_o, wready_o, mem_valid_o, mem_data_o, mem_strb_o,
           mem_beat_o, mem_last_o, done_valid_o, done_err_o
  );

endinterface

// File: rtl/axi_w_fifo.sv
// Synchronous FIFO of beat entries; full/empty derived from pointers with one extra wrap bit.
module axi_w_fifo
  import axi_w_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        push_i,
  input  fifo_entry_t din_i,
  input  logic        pop_i,
  output fifo_entry_t dout_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;
  fifo_entry_t mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the read side masks it while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/axi_w_receiver.sv
// AXI W-channel slave terminator: one burst per command, beats buffered and forwarded with index.
// Optional protocol checking (wlast/strobe errors on done_err_o) enabled by AXI_W_PROTOCOL_CHECK_EN.
module axi_w_receiver
  import axi_w_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    arstn_i,
  axi_w_if.slave  bus
);

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        cmd_ready, wready, push, pop, done_valid;
  logic        fifo_full, fifo_empty, is_last;
  fifo_entry_t din, dout;

  // Nine-bit count lets len=255 run to 256 and stop cleanly.
  assign is_last = (cnt_q == {1'b0, len_q});
  assign pop     = !fifo_empty && bus.mem_ready_i;
  assign din     = '{data: bus.wdata_i, strb: bus.wstrb_i, beat: cnt_q[7:0], last: is_last};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    cmd_ready  = 1'b0;
    wready     = 1'b0;
    push       = 1'b0;
    done_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid_i) begin
          len_d   = bus.cmd_len_i;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        wready = !fifo_full && (cnt_q <= {1'b0, len_q});
        push   = wready && bus.wvalid_i;
        if (push) cnt_d = cnt_q + 9'd1;
        if (pop && dout.last) state_d = RESP;
      end
      RESP: begin
        done_valid = 1'b1;
        if (bus.done_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  axi_w_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.cmd_ready_o  = cmd_ready;
  assign bus.wready_o     = wready;
  assign bus.done_valid_o = done_valid;
  assign bus.mem_valid_o  = !fifo_empty;
  assign bus.mem_data_o   = fifo_empty ? '0 : dout.data;
  assign bus.mem_strb_o   = fifo_empty ? '0 : dout.strb;
  assign bus.mem_beat_o   = fifo_empty ? '0 : dout.beat;
  assign bus.mem_last_o   = !fifo_empty && dout.last;

`ifdef AXI_W_PROTOCOL_CHECK_EN
  logic err_q, err_d;

  // Error is sticky across the burst and cleared once back in IDLE.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE)
      err_d = 1'b0;
    else if (push && ((bus.wlast_i != is_last) || (bus.wstrb_i == '0)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus.done_err_o = (state_q == RESP) && err_q;
`else
  logic wlast_unused;
  assign wlast_unused   = bus.wlast_i;
  assign bus.done_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi_w_receiver.sv
// Bench for axi_w_receiver: table of bursts checked through a beat scoreboard, plus corner sequences.
module tb_axi_w_receiver;
  import axi_w_pkg::*;

`ifdef AXI_W_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int NONE = 999;

  typedef struct {
    int len;
    int wlast_at;
    int zstrb_at;
    int mode;      // 0: mem_ready high, 1: random
    bit exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  axi_w_if bus ();

  axi_w_receiver dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_cnt = 0, cur_len = 0, pop_cnt = 0, hs_cnt = 0, last_pop_cyc = -10;
  int mr_mode = 0;
  fifo_entry_t sb[$];
  fifo_entry_t e;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void timeout(string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       bus.mem_ready_i = 1'b1;
      1:       bus.mem_ready_i = 1'($urandom_range(0, 1));
      default: bus.mem_ready_i = 1'b0;
    endcase
  end

  // Scoreboard: expected beats pushed on W handshakes, popped on mem handshakes.
  always @(negedge clk) begin
    if (arstn) begin
      if (bus.wready_o) chk("wready_while_full", 64'(sb.size() < 2), 64'd1);
      if (bus.mem_valid_o && bus.mem_ready_i) begin
        if (sb.size() == 0) begin
          timeout("unexpected_mem_beat");
        end else begin
          e = sb.pop_front();
          chk("mem_data", bus.mem_data_o, e.data);
          chk("mem_strb", 64'(bus.mem_strb_o), 64'(e.strb));
          chk("mem_beat", 64'(bus.mem_beat_o), 64'(e.beat));
          chk("mem_last", 64'(bus.mem_last_o), 64'(e.last));
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      if (bus.wvalid_i && bus.wready_o) begin
        e.data = bus.wdata_i;
        e.strb = bus.wstrb_i;
        e.beat = exp_cnt[7:0];
        e.last = (exp_cnt == cur_len);
        sb.push_back(e);
        exp_cnt++;
        hs_cnt++;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready_o), 64'd1);
    chk({tag, "_wready"}, 64'(bus.wready_o), 64'd0);
    chk({tag, "_mem_valid"}, 64'(bus.mem_valid_o), 64'd0);
    chk({tag, "_done_valid"}, 64'(bus.done_valid_o), 64'd0);
    chk({tag, "_done_err"}, 64'(bus.done_err_o), 64'd0);
    chk({tag, "_mem_data"}, bus.mem_data_o, 64'd0);
    chk({tag, "_mem_beat"}, 64'(bus.mem_beat_o), 64'd0);
    chk({tag, "_mem_last"}, 64'(bus.mem_last_o), 64'd0);
  endtask

  task automatic send_cmd(input int len);
    int n;
    bus.cmd_len_i   = len[7:0];
    bus.cmd_valid_i = 1'b1;
    exp_cnt = 0; cur_len = len; pop_cnt = 0; hs_cnt = 0;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready_o && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) timeout("cmd_accept");
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic send_beats(input int nbeats, input int wlast_at, input int zstrb_at);
    int n;
    for (int i = 0; i < nbeats; i++) begin
      bus.wdata_i  = {$urandom, $urandom};
      bus.wstrb_i  = (i == zstrb_at) ? 8'h00 : 8'($urandom_range(1, 255));
      bus.wlast_i  = (i == wlast_at);
      bus.wvalid_i = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.wready_o && n < 300) begin n++; @(negedge clk); end
      if (n >= 300) begin timeout("w_accept"); break; end
      @(posedge clk); #1;
    end
    bus.wvalid_i = 1'b0;
    bus.wlast_i  = 1'b0;
  endtask

  task automatic finish_burst(input bit exp_err, input int hold);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.done_valid_o && n < 600) begin n++; @(negedge clk); end
    if (n >= 600) begin
      timeout("done_valid");
    end else begin
      chk("done_after_last_pop", 64'(cyc - last_pop_cyc), 64'd1);
      chk("beats_delivered", 64'(pop_cnt), 64'(cur_len + 1));
      chk("beats_accepted", 64'(hs_cnt), 64'(cur_len + 1));
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      chk("done_err", 64'(bus.done_err_o), 64'(exp_err));
    end
    @(posedge clk); #1;
    if (hold > 0) begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_len_i   = 8'd5;
      repeat (hold) begin
        @(negedge clk);
        chk("cmd_ready_in_resp", 64'(bus.cmd_ready_o), 64'd0);
        chk("done_valid_held", 64'(bus.done_valid_o), 64'd1);
        chk("done_err_held", 64'(bus.done_err_o), 64'(exp_err));
        @(posedge clk); #1;
      end
      bus.cmd_valid_i = 1'b0;
    end
    bus.done_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.done_ready_i = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{len: 3,   wlast_at: 3,    zstrb_at: NONE, mode: 0, exp_err: 1'b0};
    vecs[1] = '{len: 0,   wlast_at: 0,    zstrb_at: NONE, mode: 0, exp_err: 1'b0};
    vecs[2] = '{len: 3,   wlast_at: 1,    zstrb_at: NONE, mode: 0, exp_err: CHK};
    vecs[3] = '{len: 5,   wlast_at: 5,    zstrb_at: NONE, mode: 1, exp_err: 1'b0};
    vecs[4] = '{len: 2,   wlast_at: 2,    zstrb_at: 1,    mode: 0, exp_err: CHK};
    vecs[5] = '{len: 1,   wlast_at: NONE, zstrb_at: NONE, mode: 1, exp_err: CHK};
    vecs[6] = '{len: 255, wlast_at: 255,  zstrb_at: NONE, mode: 0, exp_err: 1'b0};

    bus.cmd_valid_i = 1'b0; bus.cmd_len_i = '0; bus.wdata_i = '0; bus.wstrb_i = '0;
    bus.wlast_i = 1'b0; bus.wvalid_i = 1'b0; bus.mem_ready_i = 1'b1; bus.done_ready_i = 1'b0;

    #12;
    chk_reset_vals("rst");
    @(posedge clk); #1;
    arstn = 1'b1;
    @(negedge clk);
    chk_reset_vals("idle");
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      mr_mode = vecs[v].mode;
      send_cmd(vecs[v].len);
      send_beats(vecs[v].len + 1, vecs[v].wlast_at, vecs[v].zstrb_at);
      finish_burst(vecs[v].exp_err, 0);
    end

    // Backpressure: only FIFO_DEPTH beats get in while mem_ready is held low.
    mr_mode = 2;
    send_cmd(7);
    fork
      send_beats(8, 7, NONE);
    join_none
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", 64'(hs_cnt), 64'd2);
    chk("bp_wready_low", 64'(bus.wready_o), 64'd0);
    chk("bp_mem_valid", 64'(bus.mem_valid_o), 64'd1);
    mr_mode = 0;
    wait fork;
    // Completion held while a new command waits.
    finish_burst(1'b0, 4);

    mr_mode = 1;
    send_cmd(2);
    send_beats(3, 2, NONE);
    finish_burst(1'b0, 0);

    // Reset in the middle of a burst drops everything, no completion.
    mr_mode = 2;
    send_cmd(3);
    send_beats(2, NONE, NONE);
    #2;
    arstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    sb.delete();
    @(posedge clk); #1;
    arstn = 1'b1;
    mr_mode = 0;
    repeat (5) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'(bus.done_valid_o), 64'd0);
      chk("no_beat_after_rst", 64'(bus.mem_valid_o), 64'd0);
    end
    @(posedge clk); #1;
    send_cmd(1);
    send_beats(2, 1, NONE);
    finish_burst(1'b0, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_w_receiver.md
Name: axi_w_receiver

Overview:
- Slave-side terminator of the AXI write-data (W) channel.
- Accepts one burst per command (length from the AW path), buffers beats in a small FIFO, and forwards each beat to a local write port with its beat index.
- Signals burst completion to the B-response logic.
- Sits between the interconnect's W master and a memory or peripheral write port.

Parameters:
- XLEN, `XLEN (64): data width; strobe width is XLEN/8 = 8.
- FIFO_DEPTH, 2: beat buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- arstn_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  burst command valid
- cmd_ready_o  out  1  burst command ready
- cmd_len_i  in  8  AXI len (beats-1)
- wdata_i  in  XLEN  W data
- wstrb_i  in  8  W strobes
- wlast_i  in  1  W last
- wvalid_i  in  1  W valid
- wready_o  out  1  W ready
- mem_valid_o  out  1  write beat valid
- mem_ready_i  in  1  write beat accepted
- mem_data_o  out  XLEN  beat data
- mem_strb_o  out  8  beat strobes
- mem_beat_o  out  8  beat index within burst, 0..len
- mem_last_o  out  1  final beat of burst (computed from count, not wlast)
- done_valid_o  out  1  burst complete
- done_ready_i  in  1  completion accepted
- done_err_o  out  1  protocol error seen in burst

Behaviour:
- One clock, clk_i. Reset arstn_i is asynchronous and active-low.
- Reset values: cmd_ready_o=1, wready_o=0, mem_valid_o=0, done_valid_o=0, done_err_o=0, data outputs 0. FIFO is emptied, counters cleared, state=IDLE.
- States:
  - IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, latch len, beat counter=0, err=0, go to DATA.
  - DATA: wready_o = !fifo_full && (cnt <= len).
    - Each W handshake pushes {wdata, wstrb, cnt, cnt==len}, then cnt++.
    - After the beat with cnt==len is accepted, wready_o drops. Stay in DATA until the FIFO is empty and the last entry is popped, then go to RESP.
  - RESP: done_valid_o=1 and done_err_o=err, both held stable until done_ready_i; then go to IDLE.
- cmd_ready_o=0 outside IDLE. A new command is accepted only after the previous completion handshake.
- wready_o never combinationally depends on wvalid_i or mem_ready_i.
- wready_o is driven from registered full state. A full FIFO with a same-cycle pop does not raise wready_o.
- Latency: a beat accepted in cycle N is presented on mem_* in cycle N+1 at the earliest.
- FIFO pop on mem_valid_o&mem_ready_i.
- mem_* outputs are held stable while mem_valid_o=1 and mem_ready_i=0.
- Simultaneous push and pop with the FIFO not full: both occur and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer bit.
- len=0: single beat, mem_beat_o=0, mem_last_o=1.
- len=255: 256 beats; the counter is 9 bits so cnt<=len terminates correctly.
- The burst length is governed by the count only. An early wlast_i does not end the burst, and a missing wlast_i does not extend it.
- Reset mid-burst: all in-flight beats are discarded and no done is issued.

Optional Feature:
- Macro: AXI_W_PROTOCOL_CHECK_EN.
- Defined:
  - err is set if any accepted beat has wlast_i != (cnt==len).
  - err is set if any beat has wstrb_i==0.
  - err is sticky until return to IDLE and is reported on done_err_o.
- Undefined: wlast_i is ignored, done_err_o is tied 0, and no error logic is built.

Decomposition:
- Shared package axi_w_pkg:
  - state enum typedef (IDLE/DATA/RESP)
  - packed FIFO entry struct {data, strb, beat, last}
  - STRB_W constant
- One sub-module: axi_w_fifo, a generic synchronous FIFO of entry structs with full/empty.

Test Plan:
- len=3, wvalid always 1, mem_ready always 1, wlast on beat 3 -> 4 mem beats with indices 0..3, mem_last only on beat 3, done_valid 1 cycle after the last pop, done_err=0.
- len=0 single beat -> wready high for exactly one handshake, mem_beat=0, mem_last=1, done_err=0.
- len=7 with mem_ready held 0 -> wready drops after 2 beats (FIFO_DEPTH=2). Releasing mem_ready delivers all 8 beats in order with no loss.
- len=3, wlast asserted on beat 1, check macro defined -> 4 beats still accepted, done_err=1. With the macro undefined -> done_err=0.
- cmd_valid during RESP with done_ready=0 -> cmd_ready=0 until the done handshake. The next burst then starts with beat index 0.
- arstn_i pulsed low after 2 of 4 beats -> all outputs return to reset values, no done. A fresh len=1 burst completes normally.
